// File: rtl/dcache_pkg.sv
// Shared types, widths and geometry helpers for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      REFILL
   } state_e;

   localparam int OFFSET_W   = 5;
   localparam int LINE_W     = 256;
   localparam int WORD_SEL_W = 3;

   function automatic int index_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_w(input int num_lines);
      return 32 - OFFSET_W - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port
// with whole-line (refill) and single-word (store hit) write enables.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int INDEX_W   = index_w(NUM_LINES),
   parameter int TAG_W     = tag_w(NUM_LINES)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [INDEX_W-1:0]    rd_index,
   output logic                  rd_valid,
   output logic                  rd_dirty,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [LINE_W-1:0]     rd_line,
   input  logic [INDEX_W-1:0]    wr_index,
   input  logic                  line_we,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [LINE_W-1:0]     wr_line,
   input  logic                  word_we,
   input  logic [WORD_SEL_W-1:0] wr_word_sel,
   input  logic [31:0]           wr_word
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_line  = data_q[rd_index];

   // Only the status bits are reset; tag and data are meaningless while invalid.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[wr_index] <= 1'b1;
         dirty_q[wr_index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (line_we) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_line;
      end else if (word_we) begin
         data_q[wr_index][{wr_word_sel, 5'b0} +: 32] <= wr_word;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Define DCACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o statistics ports.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       p_addr_i,
   input  logic [31:0]       p_data_i,
   input  logic              p_MemRead_i,
   input  logic              p_MemWrite_i,
   output logic [31:0]       p_data_o,
   output logic              p_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]      hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int INDEX_W = index_w(NUM_LINES);
   localparam int TAG_W   = tag_w(NUM_LINES);

   state_e                state_q, state_d;
   logic [INDEX_W-1:0]    req_index;
   logic [TAG_W-1:0]      req_tag;
   logic [WORD_SEL_W-1:0] word_sel;
   logic                  rd_valid, rd_dirty;
   logic [TAG_W-1:0]      rd_tag;
   logic [LINE_W-1:0]     rd_line;
   logic                  req, hit, line_we, word_we;
   logic                  unused_addr_bits;

   assign req_index        = p_addr_i[OFFSET_W +: INDEX_W];
   assign req_tag          = p_addr_i[31 -: TAG_W];
   assign word_sel         = p_addr_i[2 +: WORD_SEL_W];
   assign unused_addr_bits = ^p_addr_i[1:0];
   assign req              = p_MemRead_i | p_MemWrite_i;
   assign hit              = rd_valid && (rd_tag == req_tag);
   assign p_data_o         = rst_i ? rd_line[{word_sel, 5'b0} +: 32] : 32'h0;

   dcache_sram #(
      .NUM_LINES (NUM_LINES)
   ) u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rd_index    (req_index),
      .rd_valid    (rd_valid),
      .rd_dirty    (rd_dirty),
      .rd_tag      (rd_tag),
      .rd_line     (rd_line),
      .wr_index    (req_index),
      .line_we     (line_we),
      .wr_tag      (req_tag),
      .wr_line     (mem_data_i),
      .word_we     (word_we),
      .wr_word_sel (word_sel),
      .wr_word     (p_data_i)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Memory handshake: mem_enable_o with mem_write_o/mem_addr_o/mem_data_o held
   // stable until the one-cycle mem_ack_i; the transfer completes on that edge.
   always_comb begin
      state_d      = state_q;
      p_stall_o    = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      line_we      = 1'b0;
      word_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (rst_i && req) begin
               if (hit) begin
                  word_we = p_MemWrite_i;
               end else begin
                  p_stall_o = 1'b1;
                  state_d   = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
               end
            end
         end
         WRITEBACK: begin
            p_stall_o    = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {rd_tag, req_index, {OFFSET_W{1'b0}}};
            mem_data_o   = rd_line;
            if (mem_ack_i) state_d = REFILL;
         end
         REFILL: begin
            p_stall_o    = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = {req_tag, req_index, {OFFSET_W{1'b0}}};
            if (mem_ack_i) begin
               line_we = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   // A hit right after a refill is the replay of a counted miss, so skip it.
   logic prev_idle_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         prev_idle_q <= 1'b1;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
      end else begin
         prev_idle_q <= (state_q == IDLE);
         if (state_q == IDLE && req && hit && prev_idle_q) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (state_q == IDLE && state_d != IDLE) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic
// against a line-level cache model and a latency-programmable memory responder.
`timescale 1ns/1ps
module tb_dcache_ctrl;

   localparam int NUM_LINES = 32;
   localparam int TXN_W     = 289;
   localparam int MAX_WAIT  = 60;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic [31:0]  p_addr_i = '0;
   logic [31:0]  p_data_i = '0;
   logic         p_MemRead_i = 1'b0;
   logic         p_MemWrite_i = 1'b0;
   logic [31:0]  p_data_o;
   logic         p_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;
`endif

   dcache_ctrl #(.NUM_LINES(NUM_LINES)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .p_addr_i     (p_addr_i),
      .p_data_i     (p_data_i),
      .p_MemRead_i  (p_MemRead_i),
      .p_MemWrite_i (p_MemWrite_i),
      .p_data_o     (p_data_o),
      .p_stall_o    (p_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,.hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [TXN_W-1:0] exp_q[$];

   // reference model: one entry per line, plus backing memory keyed by line address
   bit           m_valid [NUM_LINES];
   bit           m_dirty [NUM_LINES];
   logic [21:0]  m_tag   [NUM_LINES];
   logic [255:0] m_data  [NUM_LINES];
   logic [255:0] mem_model [logic [31:0]];
   int           s_hit  = 0;
   int           s_miss = 0;

   int               mem_lat = 1;
   int               en_cnt  = 0;
   logic [TXN_W-1:0] act_txn;

   task automatic check_eq(input string tag, input logic [TXN_W-1:0] act, input logic [TXN_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // ---------------- memory responder ----------------
   // Acks on the mem_lat-th enable cycle of each transfer and checks each
   // transfer's first cycle against the expected queue.
   always @(negedge clk_i) begin
      mem_ack_i = 1'b0;
      if (!rst_i || !mem_enable_o) begin
         en_cnt = 0;
      end else begin
         if (en_cnt == 0) begin
            act_txn = {mem_write_o, mem_addr_o, (mem_write_o ? mem_data_o : 256'b0)};
            if (exp_q.size() == 0) check_eq("txn_unexpected", act_txn, '0);
            else                   check_eq("txn", act_txn, exp_q.pop_front());
         end
         en_cnt++;
         if (en_cnt >= mem_lat) begin
            mem_ack_i  = 1'b1;
            mem_data_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : '0;
            en_cnt     = 0;
         end
      end
   end

   // ---------------- driver ----------------
   // Called right after a rising edge; returns right after the edge that
   // completes the access. lat == 0 picks a random memory latency.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat);
      int           idx, w, n, cnt, exp_stall;
      logic [21:0]  tag;
      logic [31:0]  laddr, victim;
      logic [31:0]  exp_rd;
      idx   = int'(addr[9:5]);
      w     = int'(addr[4:2]);
      tag   = addr[31:10];
      laddr = {addr[31:5], 5'b0};
      n     = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
      mem_lat   = n;
      exp_stall = 0;
      if ((rd || wr) && !(m_valid[idx] && m_tag[idx] == tag)) begin
         s_miss++;
         if (!mem_model.exists(laddr)) mem_model[laddr] = rand_line();
         if (m_valid[idx] && m_dirty[idx]) begin
            victim = {m_tag[idx], addr[9:5], 5'b0};
            exp_q.push_back({1'b1, victim, m_data[idx]});
            mem_model[victim] = m_data[idx];
            exp_stall = 2 * n + 1;
         end else begin
            exp_stall = n + 1;
         end
         exp_q.push_back({1'b0, laddr, 256'b0});
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tag;
         m_data[idx]  = mem_model[laddr];
      end else if (rd || wr) begin
         s_hit++;
      end
      if (wr) begin
         m_data[idx][w*32 +: 32] = wdata;
         m_dirty[idx] = 1'b1;
      end
      exp_rd = m_data[idx][w*32 +: 32];

      p_addr_i     = addr;
      p_data_i     = wdata;
      p_MemRead_i  = rd;
      p_MemWrite_i = wr;
      cnt = 0;
      forever begin
         @(negedge clk_i);
         if (!p_stall_o) break;
         cnt++;
         if (cnt > MAX_WAIT) break;
      end
      check_eq("stall_cycles", cnt, exp_stall);
      if (rd && !wr && cnt <= MAX_WAIT) check_eq("load_data", p_data_o, exp_rd);
      @(posedge clk_i);
      #1;
      p_MemRead_i  = 1'b0;
      p_MemWrite_i = 1'b0;
      check_eq("txn_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      s_hit  = 0;
      s_miss = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_stall"},  p_stall_o,    0);
      check_eq({tag, "_pdata"},  p_data_o,     0);
      check_eq({tag, "_enable"}, mem_enable_o, 0);
      check_eq({tag, "_write"},  mem_write_o,  0);
      check_eq({tag, "_addr"},   mem_addr_o,   0);
      check_eq({tag, "_mdata"},  mem_data_o,   0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      int          op;
      model_reset();

      // reset with a request pending: everything held low
      p_addr_i    = 32'h40;
      p_MemRead_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_reset_outputs("reset");
      p_MemRead_i = 1'b0;
      rst_i       = 1'b1;
      @(posedge clk_i);
      #1;

      // clean miss, N=3 -> 4 stall cycles
      do_access(1, 0, 32'h0000_0040, 32'h0, 3);
      // store hit then load hit
      do_access(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 1);
      do_access(1, 0, 32'h0000_0044, 32'h0, 1);
      // dirty eviction by same index, new tag, N=2 -> 5 stall cycles
      do_access(1, 0, 32'h0000_0440, 32'h0, 2);

      // reset in the middle of a refill
      exp_q.push_back({1'b0, 32'h0000_0040, 256'b0});
      mem_lat     = 4;
      p_addr_i    = 32'h0000_0040;
      p_MemRead_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check_eq("refill_enable", mem_enable_o, 1);
      check_eq("refill_addr", mem_addr_o, 32'h40);
      #1 rst_i = 1'b0;
      #1;
      check_reset_outputs("midrst");
      check_eq("midrst_txn_left", exp_q.size(), 0);
      exp_q.delete();
      model_reset();
      p_MemRead_i = 1'b0;
`ifdef DCACHE_STATS_EN
      check_eq("rst_hit_cnt", hit_cnt_o, 0);
      check_eq("rst_miss_cnt", miss_cnt_o, 0);
`endif
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // misses again; written-back word comes back from memory
      do_access(1, 0, 32'h0000_0040, 32'h0, 2);
      do_access(1, 0, 32'h0000_0044, 32'h0, 1);
      // read+write together on a hit acts as a store
      do_access(1, 1, 32'h0000_0044, 32'h1234_5678, 1);
      do_access(1, 0, 32'h0000_0044, 32'h0, 1);
`ifdef DCACHE_STATS_EN
      check_eq("dir_hit_cnt", hit_cnt_o, s_hit);
      check_eq("dir_miss_cnt", miss_cnt_o, s_miss);
`endif

      // random traffic over a few tags and indices to force conflicts
      for (int i = 0; i < 250; i++) begin
         a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) |
              ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         op = $urandom_range(0, 9);
         if (op == 0)      do_access(0, 0, a, $urandom, 0);
         else if (op <= 4) do_access(1, 0, a, $urandom, 0);
         else if (op <= 8) do_access(0, 1, a, $urandom, 0);
         else              do_access(1, 1, a, $urandom, 0);
      end
`ifdef DCACHE_STATS_EN
      check_eq("end_hit_cnt", hit_cnt_o, s_hit);
      check_eq("end_miss_cnt", miss_cnt_o, s_miss);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
